// File: rtl/io_port_ctrl.sv
// io_port_ctrl: bridges the processor I/O bus to per-port sample streams.
// Each input port has a one-entry holding register. Each output port has a
// one-entry output register. Reads from empty inputs and writes to busy outputs
// stall the processor, and stalled cycles are counted for profiling.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   proc_req_in / proc_addr_in      processor read strobe and input port index
//   proc_in_data                    read data (combinational, 0 when out of range)
//   proc_out_en / proc_addr_out     processor write strobe and output port index
//   proc_out_data                   write data
//   proc_stall                      processor hold (combinational)
//   src_data / src_valid / src_ready  input streams, port i at [i*NUBITS +: NUBITS]
//   snk_data / snk_valid / snk_ready  output streams, port j at [j*NUBITS +: NUBITS]
//   err_addr                        sticky out-of-range address flag
//   stall_cnt                       saturating count of stalled cycles
module io_port_ctrl #(
    parameter int unsigned NUBITS = 32,
    parameter int unsigned NUIOIN = 2,
    parameter int unsigned NUIOOU = 2,
    parameter int unsigned AIN    = 1,
    parameter int unsigned AOU    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       proc_req_in,
    input  logic [AIN-1:0]             proc_addr_in,
    output logic [NUBITS-1:0]          proc_in_data,
    input  logic                       proc_out_en,
    input  logic [AOU-1:0]             proc_addr_out,
    input  logic [NUBITS-1:0]          proc_out_data,
    output logic                       proc_stall,
    input  logic [NUIOIN*NUBITS-1:0]   src_data,
    input  logic [NUIOIN-1:0]          src_valid,
    output logic [NUIOIN-1:0]          src_ready,
    output logic [NUIOOU*NUBITS-1:0]   snk_data,
    output logic [NUIOOU-1:0]          snk_valid,
    input  logic [NUIOOU-1:0]          snk_ready,
    output logic                       err_addr,
    output logic [15:0]                stall_cnt
);

    localparam int unsigned CNTW = 16;

    logic [NUIOIN-1:0][NUBITS-1:0] ibuf_q, ibuf_d;
    logic [NUIOIN-1:0]             ifull_q, ifull_d;
    logic [NUIOOU-1:0][NUBITS-1:0] sdat_q, sdat_d;
    logic [NUIOOU-1:0]             svld_q, svld_d;
    logic                          err_q, err_d;
    logic [CNTW-1:0]               scnt_q, scnt_d;

    logic [NUIOIN-1:0] rd_sel;
    logic [NUIOOU-1:0] wr_sel;
    logic              in_stall;
    logic              out_stall;
    logic              rd_commit;
    logic              wr_commit;

    // Address decode; an out-of-range index leaves the select vector all zero.
    always_comb begin
        rd_sel       = '0;
        wr_sel       = '0;
        proc_in_data = '0;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            if (32'(proc_addr_in) == i) begin
                rd_sel[i]    = 1'b1;
                proc_in_data = ibuf_q[i];
            end
        end
        for (int unsigned j = 0; j < NUIOOU; j++) begin
            if (32'(proc_addr_out) == j) begin
                wr_sel[j] = 1'b1;
            end
        end
    end

    // Stall when the addressed input is empty or the addressed output cannot take a word.
    // Read and write commit together only when neither side stalls.
    always_comb begin
        in_stall   = proc_req_in & (|rd_sel) & ~(|(rd_sel & ifull_q));
        out_stall  = proc_out_en & (|(wr_sel & svld_q & ~snk_ready));
        proc_stall = in_stall | out_stall;
        rd_commit  = proc_req_in & ~proc_stall;
        wr_commit  = proc_out_en & ~proc_stall;
    end

    // Next-state for buffers, flags and counters.
    always_comb begin
        ibuf_d  = ibuf_q;
        ifull_d = ifull_q;
        sdat_d  = sdat_q;
        svld_d  = svld_q;
        err_d   = err_q;
        scnt_d  = scnt_q;

        for (int unsigned i = 0; i < NUIOIN; i++) begin
            // A read needs the port full, so it never coincides with a source accept.
            if (rd_commit && rd_sel[i]) begin
                ifull_d[i] = 1'b0;
            end
            if (src_valid[i] && !ifull_q[i]) begin
                ibuf_d[i]  = src_data[i*NUBITS +: NUBITS];
                ifull_d[i] = 1'b1;
            end
        end

        for (int unsigned j = 0; j < NUIOOU; j++) begin
            if (svld_q[j] && snk_ready[j]) begin
                svld_d[j] = 1'b0;
            end
            // Load after drain so a drain and reload in one cycle keeps valid high.
            if (wr_commit && wr_sel[j]) begin
                sdat_d[j] = proc_out_data;
                svld_d[j] = 1'b1;
            end
        end

        if ((proc_req_in && rd_sel == '0) || (proc_out_en && wr_sel == '0)) begin
            err_d = 1'b1;
        end

        if (proc_stall && scnt_q != {CNTW{1'b1}}) begin
            scnt_d = scnt_q + CNTW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_q  <= '0;
            ifull_q <= '0;
            sdat_q  <= '0;
            svld_q  <= '0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
        end else begin
            ibuf_q  <= ibuf_d;
            ifull_q <= ifull_d;
            sdat_q  <= sdat_d;
            svld_q  <= svld_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
        end
    end

    assign src_ready = ~ifull_q;
    assign snk_data  = sdat_q;
    assign snk_valid = svld_q;
    assign err_addr  = err_q;
    assign stall_cnt = scnt_q;

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Port controller between the `proc_fx` soft processor's I/O bus and the external sample streams of a filter build such as `ssf`. It replaces the bare one-hot `addr_dec` strobes with per-port holding registers and valid/ready handshakes. It stalls the processor when it reads an input port with no sample or writes an output port whose sink has not drained. Each port has a one-entry buffer, and a saturating stall counter is provided for profiling.

## Interface
Parameters:
- `NUBITS`, 32, data word width (matches the processor).
- `NUIOIN`, 2, number of input ports, 1..16.
- `NUIOOU`, 2, number of output ports, 1..16.
- `AIN`, 1, width of `proc_addr_in`.
- `AOU`, 1, width of `proc_addr_out`.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `proc_req_in`  in  1  processor input-read strobe.
- `proc_addr_in`  in  AIN  input port index.
- `proc_in_data`  out  NUBITS  read data, combinational from the addressed holding register.
- `proc_out_en`  in  1  processor output-write strobe.
- `proc_addr_out`  in  AOU  output port index.
- `proc_out_data`  in  NUBITS  write data.
- `proc_stall`  out  1  processor must hold all state and strobes while high.
- `src_data`  in  NUIOIN*NUBITS  port i occupies bits [i*NUBITS +: NUBITS].
- `src_valid`  in  NUIOIN  per-port source valid.
- `src_ready`  out  NUIOIN  per-port source ready.
- `snk_data`  out  NUIOOU*NUBITS  per-port output registers.
- `snk_valid`  out  NUIOOU  per-port sink valid.
- `snk_ready`  in  NUIOOU  per-port sink ready.
- `err_addr`  out  1  sticky flag for an out-of-range port address.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- Input port i:
  - Holding register `ibuf[i]` with flag `ifull[i]`.
  - `src_ready[i] = ~ifull[i]`.
  - `src_valid[i] & src_ready[i]` loads `ibuf[i]` and sets `ifull[i]`.
- Read:
  - `proc_req_in` with `proc_addr_in = a < NUIOIN`.
  - `ifull[a] = 1`: `proc_in_data = ibuf[a]`, and `ifull[a]` clears at the edge (commit).
  - `ifull[a] = 0`: the read is an input stall.
- Output port j:
  - Register `snk_data[j]` with `snk_valid[j]`.
  - `snk_valid[j]` stays high, and the data stays stable, until `snk_valid[j] & snk_ready[j]`.
- Write:
  - `proc_out_en` with `proc_addr_out = b < NUIOOU`.
  - Accepted when `~snk_valid[b] | snk_ready[b]`, which allows a back-to-back drain and reload in one cycle. Accept loads `proc_out_data` and sets `snk_valid[b]`.
  - Otherwise the write is an output stall.
- `proc_stall = input_stall | output_stall`, combinational.
- While `proc_stall = 1`, neither the read nor the write commits, even if one side alone could. The processor reissues both.
- Out-of-range address (`a >= NUIOIN` or `b >= NUIOOU`):
  - No stall.
  - Read returns 0; write is discarded.
  - `err_addr` sets and stays set until reset.
- `stall_cnt` increments on every cycle with `proc_stall = 1` and saturates at 16'hFFFF.
- Reset: `ifull = 0`, `ibuf = 0`, `snk_valid = 0`, `snk_data = 0`, `err_addr = 0`, `stall_cnt = 0`.
  - Hence `src_ready` is all ones and `proc_stall = 0` after reset unless a strobe targets an empty port.
  - Reset mid-transfer discards buffered samples without emitting them.

## Timing
- Source accept at edge N: the sample is readable combinationally in cycle N+1. A stalled read releases in N+1 and commits at edge N+1. `src_ready[i]` returns high in N+2.
- Per-input-port throughput: one sample per 2 cycles.
- Write accepted at edge M: `snk_valid[j]` is high and `snk_data[j]` is valid from cycle M+1.
- Per-output-port throughput: one word per cycle while `snk_ready[j]` is held high.
- `proc_stall`, `proc_in_data` and `src_ready` are combinational from current state and strobes. No registered path adds latency.
- Simultaneous events:
  - A source accept and a read of the same port cannot coincide, because ready is low while full.
  - A read and a write in the same cycle commit together or not at all.
  - Accepts on different ports are independent.

## Test plan
- Reset, then drive `src_valid[0]=1` with `src_data[31:0]=32'h0000_1234`. Expect `src_ready[0]=1` at the first edge and 0 in the following cycle. Read port 0 in the next cycle: `proc_in_data=32'h1234`, `proc_stall=0`, `src_ready[0]=1` two cycles after the accept.
- Read port 1 while empty. Expect `proc_stall=1` every cycle and `stall_cnt` incrementing. Supply 32'hDEAD_BEEF 3 cycles later: stall drops the cycle after the accept, data is correct, and `stall_cnt=4`.
- Hold `snk_ready[1]=0`, write 32'hA5 then 32'h5A to port 1. The second write stalls. Raise `snk_ready`: 32'hA5 drains, 32'h5A loads in the same cycle, and `snk_valid[1]` stays high.
- Issue a read of empty port 0 together with a write to free port 0 in the same cycle. Expect a stall with `snk_valid[0]` still 0. Fill port 0: both commit on one edge.
- With NUIOIN=3 and AIN=2, read address 3. Expect `proc_in_data=0`, no stall, and `err_addr=1` held until `rst`.
- Assert `rst` while both ports are full and stalled. Next cycle: all flags 0, `src_ready=2'b11`, `stall_cnt=0`.
